// File: rtl/mac_operand_server_pkg.sv
// Shared definitions for the MAC operand server: FSM state encoding and
// default widths. The optional accumulator write-through forward is selected
// by the MAC_ACC_BYPASS_EN macro, which is consumed in mac_acc_regfile.
package mac_pkg;

  localparam int unsigned MAC_ADDR_W    = 12;
  localparam int unsigned MAC_DATA_W    = 32;
  localparam int unsigned MAC_ACC_W     = 5;
  localparam int unsigned MAC_ACC_DEPTH = 1 << MAC_ACC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_CAP,
    S_RESP
  } mac_state_e;

endpackage

// File: rtl/mac_operand_server_if.sv
// Request/response bundle between the MAC (master) and the operand server
// (slave): operand request handshake and operand response handshake.
interface mac_operand_server_if
  import mac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MAC_ADDR_W,
  parameter int unsigned DATA_WIDTH = MAC_DATA_W,
  parameter int unsigned ACC_WIDTH  = MAC_ACC_W
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] src1_addr;
  logic [ADDR_WIDTH-1:0] src2_addr;
  logic [ACC_WIDTH-1:0]  accumulator_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] src1_data;
  logic [DATA_WIDTH-1:0] src2_data;
  logic [DATA_WIDTH-1:0] acc_data;

  modport master (
    output req_valid, src1_addr, src2_addr, accumulator_addr, rsp_ready,
    input  req_ready, rsp_valid, src1_data, src2_data, acc_data
  );

  modport slave (
    input  req_valid, src1_addr, src2_addr, accumulator_addr, rsp_ready,
    output req_ready, rsp_valid, src1_data, src2_data, acc_data
  );

endinterface

// File: rtl/mac_operand_server_acc_regfile.sv
// Accumulator register file: one synchronous write port, one asynchronous
// read port, synchronous reset clearing every entry.
// MAC_ACC_BYPASS_EN: when defined, a read of the entry being written in the
// same cycle returns the incoming write data; otherwise it returns the
// stored (pre-write) value.
module mac_acc_regfile
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MAC_DATA_W,
  parameter int unsigned ACC_WIDTH  = MAC_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ACC_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ACC_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ACC_WIDTH;

  logic [DATA_WIDTH-1:0] entries [DEPTH];

  // Storage: reset clears all entries, otherwise honour the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[ACC_WIDTH'(i)] <= '0;
      end
    end else if (wr_en) begin
      entries[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read, optionally forwarding a same-cycle write.
  always_comb begin
`ifdef MAC_ACC_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = entries[rd_addr];
    end
`else
    rd_data = entries[rd_addr];
`endif
  end

endmodule

// File: rtl/mac_operand_server.sv
// Memory-side operand server for the MAC unit. Accepts a request of two
// memory addresses plus an accumulator index, reads both operands from a
// single-port synchronous memory (one-cycle read latency), reads the
// accumulator file and presents all three values until consumed. Owns the
// accumulator file and accepts writebacks in every state.
// Optional macro MAC_ACC_BYPASS_EN (see mac_acc_regfile) selects write-through
// forwarding when a writeback hits the latched index during S_CAP.
module mac_operand_server
  import mac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MAC_ADDR_W,
  parameter int unsigned DATA_WIDTH = MAC_DATA_W,
  parameter int unsigned ACC_WIDTH  = MAC_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_operand_server_if.slave   bus,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  acc_wr_en,
  input  logic [ACC_WIDTH-1:0]  acc_wr_addr,
  input  logic [DATA_WIDTH-1:0] acc_wr_data
);

  mac_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] src1_addr_q;
  logic [ADDR_WIDTH-1:0] src2_addr_q;
  logic [ACC_WIDTH-1:0]  acc_idx_q;
  logic [DATA_WIDTH-1:0] src1_data_q;
  logic [DATA_WIDTH-1:0] src2_data_q;
  logic [DATA_WIDTH-1:0] acc_data_q;
  logic [DATA_WIDTH-1:0] acc_rd_data;
  logic                  req_ready;
  logic                  rsp_valid;

  mac_acc_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (acc_wr_en),
    .wr_addr (acc_wr_addr),
    .wr_data (acc_wr_data),
    .rd_addr (acc_idx_q),
    .rd_data (acc_rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the request addresses on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      src1_addr_q <= '0;
      src2_addr_q <= '0;
      acc_idx_q   <= '0;
    end else if ((state == S_IDLE) && bus.req_valid) begin
      src1_addr_q <= bus.src1_addr;
      src2_addr_q <= bus.src2_addr;
      acc_idx_q   <= bus.accumulator_addr;
    end
  end

  // Capture operand 1 in S_RD2, operand 2 and the accumulator in S_CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      src1_data_q <= '0;
      src2_data_q <= '0;
      acc_data_q  <= '0;
    end else begin
      if (state == S_RD2) begin
        src1_data_q <= mem_rd_data;
      end
      if (state == S_CAP) begin
        src2_data_q <= mem_rd_data;
        acc_data_q  <= acc_rd_data;
      end
    end
  end

  // Next-state logic plus handshake and memory strobes.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = src2_addr_q;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = S_RD1;
        end
      end
      S_RD1: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = src1_addr_q;
        state_next  = S_RD2;
      end
      S_RD2: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = src2_addr_q;
        state_next  = S_CAP;
      end
      S_CAP: begin
        state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.src1_data = src1_data_q;
  assign bus.src2_data = src2_data_q;
  assign bus.acc_data  = acc_data_q;

endmodule

// File: tb/tb_mac_operand_server.sv
// Self-checking bench for mac_operand_server. Responses are predicted when a
// request is issued and compared by an independent monitor on handshake.
module tb_mac_operand_server;
  import mac_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_operand_server_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(CW)) bus ();

  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          acc_wr_en;
  logic [CW-1:0] acc_wr_addr;
  logic [DW-1:0] acc_wr_data;

  mac_operand_server #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .acc_wr_en   (acc_wr_en),
    .acc_wr_addr (acc_wr_addr),
    .acc_wr_data (acc_wr_data)
  );

  // Data memory and accumulator reference contents.
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] acc_ref [32];

  // Synchronous single-port memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  typedef struct {
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [DW-1:0] acc;
  } rsp_t;

  rsp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: samples just before each rising edge; pops on response handshake.
  always @(negedge clk) begin
    rsp_t e;
    #4;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_src1", bus.src1_data, e.s1);
        check("rsp_src2", bus.src2_data, e.s2);
        check("rsp_acc", bus.acc_data, e.acc);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Writeback of one accumulator entry (called at a falling edge).
  task automatic acc_write(input logic [CW-1:0] idx, input logic [DW-1:0] data);
    acc_wr_en   = 1'b1;
    acc_wr_addr = idx;
    acc_wr_data = data;
    @(negedge clk);
    acc_wr_en   = 1'b0;
    acc_ref[idx] = data;
  endtask

  // Issue one request, predict its response, check the read sequence and
  // latency. Optionally pulses a colliding writeback while in S_CAP.
  // Returns at the falling edge where rsp_valid must first be high.
  task automatic issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [CW-1:0] idx, input bit cap_wr,
                       input logic [DW-1:0] wd);
    bit ok;
    rsp_t e;
    wait_ready(ok);
    check("req_ready_wait", {63'd0, ok}, 64'd1);
    if (!ok) return;
    bus.req_valid        = 1'b1;
    bus.src1_addr        = a1;
    bus.src2_addr        = a2;
    bus.accumulator_addr = idx;
    e.s1 = mem[a1];
    e.s2 = mem[a2];
    e.acc = acc_ref[idx];
`ifdef MAC_ACC_BYPASS_EN
    if (cap_wr) e.acc = wd;
`endif
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rd1_en", mem_rd_en, 1);
    check("rd1_addr", mem_rd_addr, a1);
    check("busy_req_ready", bus.req_ready, 0);
    @(negedge clk);
    check("rd2_en", mem_rd_en, 1);
    check("rd2_addr", mem_rd_addr, a2);
    @(negedge clk);
    check("cap_rd_en", mem_rd_en, 0);
    check("cap_rsp_valid", bus.rsp_valid, 0);
    if (cap_wr) begin
      acc_wr_en   = 1'b1;
      acc_wr_addr = idx;
      acc_wr_data = wd;
      acc_ref[idx] = wd;
    end
    @(negedge clk);
    acc_wr_en = 1'b0;
    check("latency_rsp_valid", bus.rsp_valid, 1);
  endtask

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    logic [AW-1:0] ra1, ra2;
    logic [CW-1:0] ridx;
    bit bp;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) acc_ref[i] = '0;
    bus.req_valid        = 1'b0;
    bus.src1_addr        = '0;
    bus.src2_addr        = '0;
    bus.accumulator_addr = '0;
    bus.rsp_ready        = 1'b1;
    acc_wr_en   = 1'b0;
    acc_wr_addr = '0;
    acc_wr_data = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_src1", bus.src1_data, 0);
    check("rst_src2", bus.src2_data, 0);
    check("rst_acc", bus.acc_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic fetch.
    mem[12'h010] = 32'h3;
    mem[12'h020] = 32'h5;
    acc_write(5'd2, 32'h64);
    issue(12'h010, 12'h020, 5'd2, 1'b0, '0);
    @(negedge clk);

    // Backpressure: response held, extra request ignored.
    mem[12'h100] = 32'h1234_5678;
    mem[12'h200] = 32'h9ABC_DEF0;
    acc_write(5'd3, 32'h0BAD_F00D);
    bus.rsp_ready = 1'b0;
    issue(12'h100, 12'h200, 5'd3, 1'b0, '0);
    for (int c = 0; c < 6; c++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_mem_rd_en", mem_rd_en, 0);
      check("bp_src1", bus.src1_data, mem[12'h100]);
      check("bp_src2", bus.src2_data, mem[12'h200]);
      check("bp_acc", bus.acc_data, acc_ref[3]);
      bus.req_valid = (c == 2);
      bus.src1_addr = 12'h555;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_after_req_ready", bus.req_ready, 1);
    check("bp_after_mem_rd_en", mem_rd_en, 0);

    // Collision in S_CAP, then follow-up read of the written value.
    mem[12'h030] = 32'hA;
    mem[12'h031] = 32'hB;
    acc_write(5'd7, 32'h10);
    issue(12'h030, 12'h031, 5'd7, 1'b1, 32'h99);
    @(negedge clk);
    issue(12'h030, 12'h031, 5'd7, 1'b0, '0);
    @(negedge clk);

    // Reset mid-operation in S_RD2; no response may follow.
    acc_write(5'd5, 32'h55);
    wait_ready(ok);
    check("rstmid_ready", {63'd0, ok}, 64'd1);
    bus.req_valid        = 1'b1;
    bus.src1_addr        = 12'h040;
    bus.src2_addr        = 12'h041;
    bus.accumulator_addr = 5'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_in_rd2", mem_rd_addr, 12'h041);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_rsp_valid", bus.rsp_valid, 0);
    check("rstmid_req_ready", bus.req_ready, 1);
    check("rstmid_mem_rd_en", mem_rd_en, 0);
    check("rstmid_src1", bus.src1_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) acc_ref[i] = '0;
    repeat (6) @(negedge clk);
    check("rstmid_no_stale", bus.rsp_valid, 0);
    for (int i = 0; i < 32; i++) begin
      issue(AW'($urandom), AW'($urandom), CW'(i), 1'b0, '0);
      @(negedge clk);
    end

    // Back-to-back with writeback at the top index.
    mem[12'hFFE] = 32'hA5A5_A5A5;
    mem[12'h001] = 32'h8000_0001;
    acc_write(5'd31, 32'h1357_9BDF);
    issue(12'hFFE, 12'h001, 5'd31, 1'b0, '0);
    acc_write(5'd31, 32'hFFFF_FFFF);
    issue(12'hFFE, 12'h001, 5'd31, 1'b0, '0);
    @(negedge clk);

    // Same address for both operands.
    mem[12'hFFF] = 32'hDEAD_BEEF;
    issue(12'hFFF, 12'hFFF, 5'd0, 1'b0, '0);
    @(negedge clk);

    // Randomized traffic with backpressure and writebacks.
    for (int n = 0; n < 25; n++) begin
      ra1  = AW'($urandom);
      ra2  = AW'($urandom);
      ridx = CW'($urandom);
      mem[ra1] = $urandom;
      mem[ra2] = $urandom;
      if ($urandom_range(0, 1) == 1) acc_write(CW'($urandom), $urandom);
      bp = ($urandom_range(0, 1) == 1);
      bus.rsp_ready = !bp;
      issue(ra1, ra2, ridx, ($urandom_range(0, 2) == 0), $urandom);
      if (bp) begin
        acc_write(ridx, $urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.rsp_ready = 1'b1;
      end
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_server.md
Name: mac_operand_server

Overview:
- Memory-side responder for the multiply-and-accumulate unit.
- Accepts an operand request (two memory addresses plus one accumulator index) over a valid/ready handshake.
- Fetches both operands from a single-port synchronous data memory and reads the accumulator register file, then returns all three values.
- Owns the accumulator register file and accepts result writeback from the MAC. It is the read/serve end of the MAC's operand interface.

Parameters:
- ADDR_WIDTH, 12, data-memory address width.
- DATA_WIDTH, 32, operand, accumulator and result width.
- ACC_WIDTH, 5, accumulator index width; the file holds 2**ACC_WIDTH entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operand request valid.
- req_ready  out  1  high only in S_IDLE.
- src1_addr  in  ADDR_WIDTH  operand 1 memory address.
- src2_addr  in  ADDR_WIDTH  operand 2 memory address.
- accumulator_addr  in  ACC_WIDTH  accumulator index.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  memory read address.
- mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- src1_data  out  DATA_WIDTH  fetched operand 1.
- src2_data  out  DATA_WIDTH  fetched operand 2.
- acc_data  out  DATA_WIDTH  accumulator value.
- acc_wr_en  in  1  accumulator writeback strobe.
- acc_wr_addr  in  ACC_WIDTH  writeback index.
- acc_wr_data  in  DATA_WIDTH  writeback value.

Behaviour:
- Reset (synchronous, active-high, on clk):
  - state=S_IDLE.
  - rsp_valid=0; src1_data, src2_data, acc_data=0.
  - mem_rd_en=0, mem_rd_addr=0.
  - All accumulator entries = 0.
  - Reset mid-operation abandons the request; no response is produced.
- FSM states: S_IDLE, S_RD1, S_RD2, S_CAP, S_RESP.
  - S_IDLE: req_ready=1. On req_valid, latch all three addresses and go to S_RD1.
  - S_RD1: mem_rd_en=1, mem_rd_addr=src1 address. Go to S_RD2.
  - S_RD2: mem_rd_en=1, mem_rd_addr=src2 address. Capture mem_rd_data into src1_data. Go to S_CAP.
  - S_CAP: mem_rd_en=0. Capture mem_rd_data into src2_data. Read acc_data from the file at the latched index. Go to S_RESP.
  - S_RESP: rsp_valid=1, all three data outputs held stable. On rsp_ready, go to S_IDLE with rsp_valid=0 next cycle.
- Latency: request accepted at edge N gives rsp_valid=1 from edge N+3.
  - Minimum request-to-request spacing is 5 cycles.
  - No request overlap; req_ready=0 in every state except S_IDLE.
- mem_rd_en and mem_rd_addr are combinational from state and latched addresses.
  - mem_rd_addr outside S_RD1/S_RD2 holds the src2 address (don't-care for memory).
- Writeback:
  - acc_wr_en is honoured in every state, including during reset release.
  - It writes the file at the clock edge.
  - A writeback during S_RESP does not alter the acc_data already held.
- Same-cycle writeback and read: acc_wr_en with acc_wr_addr equal to the latched index while in S_CAP is governed by the optional feature.
- Arithmetic: none. Values pass through unmodified at full DATA_WIDTH.
- src1_addr may equal src2_addr; two reads are still issued.

Optional Feature:
- Macro: MAC_ACC_BYPASS_EN.
- Defined: on the S_CAP collision, acc_data takes acc_wr_data (write-through forward).
- Undefined: on the S_CAP collision, acc_data takes the pre-write file contents. The write still lands in the file.

Decomposition:
- Package mac_pkg holds:
  - state enum (S_IDLE..S_RESP);
  - default width constants (MAC_ADDR_W=12, MAC_DATA_W=32, MAC_ACC_W=5);
  - derived MAC_ACC_DEPTH=32.
- Sub-module mac_acc_regfile:
  - 1 write port, 1 asynchronous read port;
  - synchronous reset clearing all entries;
  - MAC_ACC_BYPASS_EN forwarding mux inside it.
- FSM and memory sequencing stay in the top module.

Test Plan:
- Basic fetch: memory [0x010]=0x00000003, [0x020]=0x00000005, acc[2]=0x64. Request (0x010, 0x020, 2) -> mem_rd_addr 0x010 then 0x020 on consecutive cycles; rsp_valid 3 cycles after accept with src1=3, src2=5, acc=0x64.
- Backpressure: hold rsp_ready=0 for 6 cycles -> rsp_valid and all data stable; req_ready=0 throughout; a req_valid pulse is ignored (no memory reads).
- Collision: acc[7]=0x10; pulse acc_wr_en, acc_wr_addr=7, acc_wr_data=0x99 in S_CAP of request with index 7 -> acc_data=0x99 with MAC_ACC_BYPASS_EN, 0x10 without; a follow-up request reads 0x99 in both builds.
- Reset mid-operation: assert rst in S_RD2 -> next cycle rsp_valid=0, req_ready=1, mem_rd_en=0, acc[0..31]=0; no stale response appears afterwards.
- Back-to-back with writeback: request index 31, return acc_wr 31 ← 0xFFFFFFFF, then request index 31 again -> second response acc_data=0xFFFFFFFF; address wrap, full-width data intact.
- Same address: src1_addr=src2_addr=0xFFF, memory [0xFFF]=0xDEADBEEF -> two reads issued; src1=src2=0xDEADBEEF.
